pc_unit: RTL

Parametrised program-counter unit for the single-cycle/early-pipeline core. Holds the fetch PC and selects the next PC from sequential, conditional branch, JAL, JALR and external flush redirect. Adds stall hold, misaligned-target trap and a RAS_DEPTH-entry return-address stack for call/return tracking. Sits between control/ALU outputs and instruction memory address.

---
 rtl/pc_unit_if.sv | 34 +++
 rtl/pc_unit.sv | 94 +++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// Control/status bundle between the decode/ALU side (master) and the program-counter unit (slave).
interface pc_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                stall;
  logic                flush;
  logic [PC_WIDTH-1:0] flush_target;
  logic                branch;
  logic                branch_ne;
  logic                zero_flag;
  logic                jal;
  logic                jalr;
  logic [PC_WIDTH-1:0] imm;
  logic [PC_WIDTH-1:0] rs1_val;
  logic                ras_push;
  logic                ras_pop;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                misaligned;
  logic                ras_empty;
  logic                ras_full;

  modport master (
    output stall, flush, flush_target, branch, branch_ne, zero_flag,
           jal, jalr, imm, rs1_val, ras_push, ras_pop,
    input  pc, pc_plus4, misaligned, ras_empty, ras_full
  );

  modport slave (
    input  stall, flush, flush_target, branch, branch_ne, zero_flag,
           jal, jalr, imm, rs1_val, ras_push, ras_pop,
    output pc, pc_plus4, misaligned, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with next-PC selection, stall/flush, misaligned-target trap
// and a circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  localparam int             PTR_W          = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] RAS_FULL_COUNT = (PTR_W+1)'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] jalr_sum;
  logic [PC_WIDTH-1:0] ras_top;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_ptr;
  logic [PTR_W-1:0]    ras_ptr_dec;
  logic [PTR_W:0]      ras_count;
  logic                misaligned_q;
  logic                ras_empty;
  logic                ras_full;
  logic                branch_taken;
  logic                is_jump;
  logic                take_jump;
  logic                use_ras;
  logic                target_bad;
  logic                do_push;

  assign pc_plus4     = pc_q + PC_WIDTH'(4);
  assign jalr_sum     = bus.rs1_val + bus.imm;
  assign ras_ptr_dec  = ras_ptr - PTR_W'(1);
  assign ras_top      = ras_mem[ras_ptr_dec];
  assign ras_empty    = (ras_count == '0);
  assign ras_full     = (ras_count == RAS_FULL_COUNT);
  assign branch_taken = bus.branch & (bus.zero_flag ^ bus.branch_ne);
  assign is_jump      = bus.jal | bus.jalr;
  assign take_jump    = is_jump | branch_taken;
  assign use_ras      = bus.jalr & bus.ras_pop & ~ras_empty;
  assign do_push      = is_jump & bus.ras_push;

  always_comb begin
    target = pc_q + bus.imm;
    if (bus.jalr) begin
      if (use_ras) target = ras_top;
      else         target = {jalr_sum[PC_WIDTH-1:1], 1'b0};
    end
  end

  assign target_bad = take_jump & (target[1:0] != 2'b00);

  // The stack pointer addresses the next free slot; overflow wraps and overwrites the oldest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
      ras_ptr      <= '0;
      ras_count    <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (bus.flush) begin
      pc_q         <= bus.flush_target;
      misaligned_q <= 1'b0;
    end else if (bus.stall) begin
      misaligned_q <= 1'b0;
    end else if (target_bad) begin
      misaligned_q <= 1'b1;
    end else begin
      misaligned_q <= 1'b0;
      pc_q         <= take_jump ? target : pc_plus4;
      if (do_push && use_ras) begin
        ras_mem[ras_ptr_dec] <= pc_plus4;
      end else if (do_push) begin
        ras_mem[ras_ptr] <= pc_plus4;
        ras_ptr          <= ras_ptr + PTR_W'(1);
        if (!ras_full) ras_count <= ras_count + (PTR_W+1)'(1);
      end else if (use_ras) begin
        ras_ptr   <= ras_ptr_dec;
        ras_count <= ras_count - (PTR_W+1)'(1);
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.misaligned = misaligned_q;
  assign bus.ras_empty  = ras_empty;
  assign bus.ras_full   = ras_full;

endmodule
